polyphase_interp_fir: RTL and testbench

POLYPHASE_INTERP_FIR -- requirements
Module: polyphase_interp_fir

---
 rtl/polyphase_interp_fir.sv | 169 ++++++++++++++++
 tb/tb_polyphase_interp_fir.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/polyphase_interp_fir.sv
// Polyphase interpolating FIR filter.
// Each accepted input sample yields R outputs, one per polyphase branch. Each
// output takes TPP multiply-accumulate cycles plus one handshake cycle.
// The taps are loaded serially after each enable. The tap RAM keeps its
// contents through reset, but the load count always restarts at zero.
module polyphase_interp_fir #(
  parameter int G_DWIDTH         = 24,
  parameter int G_TAP_RES        = 16,
  parameter int G_MAX_RATE       = 8,
  parameter int G_TAPS_PER_PHASE = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          bypass,
  input  logic [$clog2(G_MAX_RATE):0]   rate,
  input  logic [1:0]                    gain_shift,
  input  logic                          tap_wr,
  input  logic [G_TAP_RES-1:0]          tap_val,
  output logic                          tap_wr_done,
  input  logic [G_DWIDTH-1:0]           din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic [G_DWIDTH-1:0]           dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          dout_last
);

  localparam int TPP   = G_TAPS_PER_PHASE;
  localparam int RW    = $clog2(G_MAX_RATE) + 1;
  localparam int NTAPS = G_MAX_RATE * TPP;
  localparam int KW    = $clog2(NTAPS + 1);
  localparam int AD    = $clog2(NTAPS);
  localparam int JW    = (TPP > 1) ? $clog2(TPP) : 1;
  localparam int PW    = G_DWIDTH + G_TAP_RES;
  localparam int AW    = PW + $clog2(TPP);
  localparam int SW    = AW + 3;

  typedef enum logic [1:0] {LOAD, IDLE, MAC, OUT} state_t;

  state_t                      state_q, state_d;
  logic [RW-1:0]               rate_q, rate_eff;
  logic [1:0]                  gain_q;
  logic [KW-1:0]               k_q, ntaps_cur;
  logic [RW-1:0]               p_q;
  logic [JW-1:0]               j_q;
  logic                        byp_q;
  logic signed [G_DWIDTH-1:0]  hist_q [TPP];
  logic signed [G_TAP_RES-1:0] tap_ram [NTAPS];
  logic signed [AW-1:0]        acc_q, acc_d;
  logic signed [PW-1:0]        prod;
  logic signed [SW-1:0]        scaled;
  logic [SW-G_DWIDTH:0]        hi;
  logic [G_DWIDTH-1:0]         sat_res;
  logic [AD-1:0]               tap_addr;
  logic                        clr, tap_we, xfer, last_mac, p_last;

  assign clr       = reset | ~enable;
  assign rate_eff  = (rate == '0) ? RW'(1) :
                     (rate > RW'(G_MAX_RATE)) ? RW'(G_MAX_RATE) : rate;
  assign ntaps_cur = KW'(rate_q) * KW'(TPP);
  assign tap_wr_done = (k_q == ntaps_cur);
  assign din_ready = (state_q == IDLE);
  assign xfer      = din_valid & din_ready;
  assign last_mac  = (j_q == JW'(TPP - 1));
  assign p_last    = (p_q == rate_q - RW'(1));
  // Taps are only writable before the datapath is running, and only up to R*TPP entries.
  assign tap_we    = enable & ~reset & tap_wr & (k_q < ntaps_cur) &
                     ((state_q == LOAD) | (state_q == IDLE));

  // Branch p uses taps p, p+R, p+2R, ... against history x[0], x[1], ...
  assign tap_addr = AD'(p_q) + AD'(j_q) * AD'(rate_q);
  assign prod     = hist_q[j_q] * tap_ram[tap_addr];
  assign acc_d    = acc_q + AW'(prod);

  // Requantize from Q1.(TAP_RES-1), apply gain, then saturate on the upper bits.
  assign scaled  = (SW'(acc_d) >>> (G_TAP_RES - 1)) <<< gain_q;
  assign hi      = scaled[SW-1:G_DWIDTH-1];
  assign sat_res = ((&hi) | ~(|hi)) ? scaled[G_DWIDTH-1:0] :
                   scaled[SW-1] ? {1'b1, {(G_DWIDTH-1){1'b0}}}
                                : {1'b0, {(G_DWIDTH-1){1'b1}}};

  // Configuration tracks the inputs while disabled and freezes once enabled.
  always_ff @(posedge clk) begin
    if (!enable) begin
      rate_q <= rate_eff;
      gain_q <= gain_shift;
    end else if (reset) begin
      rate_q <= RW'(1);
      gain_q <= 2'd0;
    end
  end

  // Tap storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (tap_we) tap_ram[k_q[AD-1:0]] <= tap_val;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (clr) state_q <= LOAD;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD: if (tap_wr_done || bypass) state_d = IDLE;
      IDLE: if (xfer) state_d = bypass ? OUT : MAC;
      MAC:  if (last_mac) state_d = OUT;
      OUT:  if (dout_ready) state_d = (byp_q || p_last) ? IDLE : MAC;
      default: state_d = LOAD;
    endcase
  end

  // Datapath: load counter, history, accumulator and the output register.
  always_ff @(posedge clk) begin
    if (clr) begin
      k_q        <= '0;
      p_q        <= '0;
      j_q        <= '0;
      acc_q      <= '0;
      byp_q      <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      for (int i = 0; i < TPP; i++) hist_q[i] <= '0;
    end else begin
      if (tap_we) k_q <= k_q + KW'(1);
      case (state_q)
        IDLE: if (xfer) begin
          if (bypass) begin
            dout       <= din;
            dout_valid <= 1'b1;
            dout_last  <= 1'b1;
            byp_q      <= 1'b1;
          end else begin
            for (int i = TPP - 1; i > 0; i--) hist_q[i] <= hist_q[i-1];
            hist_q[0] <= din;
            p_q       <= '0;
            j_q       <= '0;
            acc_q     <= '0;
            byp_q     <= 1'b0;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          j_q   <= j_q + JW'(1);
          if (last_mac) begin
            j_q        <= '0;
            dout       <= sat_res;
            dout_valid <= 1'b1;
            dout_last  <= p_last;
          end
        end
        OUT: if (dout_ready) begin
          dout_valid <= 1'b0;
          dout_last  <= 1'b0;
          acc_q      <= '0;
          if (!byp_q && !p_last) p_q <= p_q + RW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_polyphase_interp_fir.sv
// Scoreboard bench for polyphase_interp_fir: stimulus pushes hand-computed
// outputs, a monitor pops and compares on every output handshake.
module tb_polyphase_interp_fir;

  localparam int TPP = 8;

  logic        clk = 1'b0;
  logic        reset, enable, bypass, tap_wr, tap_wr_done;
  logic [3:0]  rate;
  logic [1:0]  gain_shift;
  logic [15:0] tap_val;
  logic [23:0] din, dout;
  logic        din_valid, din_ready, dout_valid, dout_ready, dout_last;

  polyphase_interp_fir dut (
    .clk(clk), .reset(reset), .enable(enable), .bypass(bypass), .rate(rate),
    .gain_shift(gain_shift), .tap_wr(tap_wr), .tap_val(tap_val),
    .tap_wr_done(tap_wr_done), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last)
  );

  always #5 clk = ~clk;

  typedef struct { logic [23:0] d; logic last; } exp_t;
  exp_t        q[$];
  int          errors = 0, checks = 0, n_push = 0, n_hs = 0;
  logic [15:0] tap_buf [64];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void push(logic [23:0] d, logic l);
    exp_t e;
    e.d = d; e.last = l;
    q.push_back(e);
    n_push++;
  endfunction

  // Monitor: every output handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && dout_valid && dout_ready) begin
      exp_t e;
      n_hs++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got %0h last %0b with empty queue", dout, dout_last);
      end else begin
        e = q.pop_front();
        if (dout !== e.d || dout_last !== e.last) begin
          errors++;
          $display("FAIL out_%0d: got %0h last %0b expected %0h last %0b",
                   n_hs, dout, dout_last, e.d, e.last);
        end
      end
    end
  end

  task automatic cfg(input int r, input int g);
    enable = 1'b0; rate = 4'(r); gain_shift = 2'(g);
    @(posedge clk); #1;
    @(posedge clk); #1;
    enable = 1'b1;
  endtask

  // Serial tap load; optionally holds din_valid high to check input gating,
  // otherwise issues one extra write that must be ignored.
  task automatic load_taps(input int n, input bit hold_din);
    for (int i = 0; i < n; i++) begin
      tap_wr = 1'b1; tap_val = tap_buf[i];
      @(negedge clk);
      chk("done_early", tap_wr_done, 0);
      if (hold_din) chk("gate_rdy", din_ready, 0);
      @(posedge clk); #1;
    end
    tap_wr = 1'b0;
    @(negedge clk);
    chk("done_set", tap_wr_done, 1);
    if (hold_din) begin
      chk("gate_rdy_done", din_ready, 0);
      @(negedge clk);
      chk("rdy_after_done", din_ready, 1);
      @(posedge clk); #1;
      din_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      tap_wr = 1'b1; tap_val = 16'h1234;
      @(posedge clk); #1;
      tap_wr = 1'b0;
      @(negedge clk);
      chk("done_hold_extra", tap_wr_done, 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input logic [23:0] d);
    int n = 0;
    din = d; din_valid = 1'b1;
    @(negedge clk);
    while (!din_ready && n < 2000) begin @(negedge clk); n++; end
    chk("send_ready", din_ready, 1);
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    chk("drain", q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic impulse_taps(input int n);
    for (int i = 0; i < 64; i++) tap_buf[i] = 16'h0;
    tap_buf[0] = 16'h4000;
  endtask

  initial begin
    int lat;
    reset = 1'b1; enable = 1'b1; bypass = 1'b0; rate = 4'd4; gain_shift = 2'd0;
    tap_wr = 1'b0; tap_val = '0; din = '0; din_valid = 1'b0; dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", dout_valid, 0);
    chk("rst_ready", din_ready, 0);
    chk("rst_done", tap_wr_done, 0);
    chk("rst_dout", dout, 0);
    @(posedge clk); #1;

    // Impulse, R=4, gain 0, with din held valid across the tap load.
    cfg(4, 0);
    impulse_taps(32);
    push(24'd500, 0); push(24'd0, 0); push(24'd0, 0); push(24'd0, 1);
    din = 24'd1000; din_valid = 1'b1;
    load_taps(32, 1);
    drain();

    // Backpressure: first output held for 10 cycles.
    dout_ready = 1'b0;
    push(24'd500, 0); push(24'd0, 0); push(24'd0, 0); push(24'd0, 1);
    send(24'd1000);
    lat = 0;
    while (!dout_valid && lat < 100) begin @(negedge clk); lat++; end
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", dout_valid, 1);
      chk("bp_dout", dout, 24'd500);
      chk("bp_last", dout_last, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    dout_ready = 1'b1;
    drain();

    // Impulse with gain 1 and first-output latency.
    cfg(4, 1);
    load_taps(32, 0);
    push(24'd1000, 0); push(24'd0, 0); push(24'd0, 0); push(24'd0, 1);
    send(24'd1000);
    lat = 1;
    @(negedge clk);
    while (!dout_valid && lat < 50) begin @(negedge clk); lat++; end
    chk("latency", lat, TPP + 1);
    drain();

    // Reset during MAC cycle 3 discards the run; then bypass.
    send(24'd1000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mac_rst_valid", dout_valid, 0);
    chk("mac_rst_ready", din_ready, 0);
    chk("mac_rst_done", tap_wr_done, 0);
    @(posedge clk); #1;
    bypass = 1'b1;
    push(24'h123456, 1);
    send(24'h123456);
    @(negedge clk);
    chk("byp_valid_t1", dout_valid, 1);
    chk("byp_dout_t1", dout, 24'h123456);
    drain();
    bypass = 1'b0;

    // Rate 0 behaves as rate 1: 8 taps complete the load, single output.
    cfg(0, 0);
    load_taps(8, 0);
    push(24'd500, 1);
    send(24'd1000);
    drain();

    // Phase mapping, R=2, h[k]=k*256.
    cfg(2, 0);
    for (int k = 0; k < 16; k++) tap_buf[k] = 16'(k * 256);
    load_taps(16, 0);
    for (int n = 0; n < 9; n++) begin
      for (int p = 0; p < 2; p++)
        push((n < 8) ? 24'(2 * (2 * n + p)) : 24'd0, p == 1);
      send((n == 0) ? 24'h000100 : 24'h0);
    end
    drain();

    // Saturation, R=2, taps 0x7FFF, gain 3.
    for (int k = 0; k < 16; k++) tap_buf[k] = 16'h7FFF;
    cfg(2, 3);
    load_taps(16, 0);
    for (int n = 0; n < 3; n++) begin
      push(24'h7FFFFF, 0); push(24'h7FFFFF, 1);
      send(24'h7FFFFF);
    end
    drain();
    cfg(2, 3);
    load_taps(16, 0);
    for (int n = 0; n < 3; n++) begin
      push(24'h800000, 0); push(24'h800000, 1);
      send(24'h800000);
    end
    drain();

    repeat (5) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    chk("xfer_count", n_hs, n_push);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
